tia_audio: RTL and testbench
============================

# tia_audio

Two-channel TIA-compatible audio generator and mixer; feeds the 5-bit delta-sigma DAC input directly. Holds the AUDC/AUDF/AUDV registers written by the CPU bus decode, runs per-channel frequency dividers and polynomial counters on the audio tick, and outputs the unsigned sum of both channel amplitudes.

## Interface
Parameters:
- none; all widths are fixed by the TIA register map.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high.
- AudTick  in  1  one-Clk-wide audio-rate enable, nominally 2 per scanline (~31.4 kHz).
- WrEn  in  1  register write strobe.
- WrAddr  in  3  register select: 0 AUDC0, 1 AUDC1, 2 AUDF0, 3 AUDF1, 4 AUDV0, 5 AUDV1; 6–7 ignored.
- WrData  in  5  write data; AUDC and AUDV use [3:0], AUDF uses [4:0].
- AudioOut  out  5  mixed sample, range 0..30; drives the DAC input.

## Operation
- Registers: AUDCn[3:0], AUDFn[4:0], AUDVn[3:0]. All reset to 0.
- Divider per channel: 5-bit counter, advances only on AudTick. If counter == AUDFn, it clears to 0 and a channel step is issued; otherwise it increments. The step period is therefore AUDFn+1 ticks.
- LFSRs per channel. Each shifts right; the new MSB is the feedback bit. All advance on step unless noted.
  - poly4: fb = p[0]^p[1].
  - poly5: fb = p[0]^p[2].
  - poly9: fb = p[0]^p[4].
  - All seed to all-ones on reset.
- Aux counters per channel: div3 (0..2) and div31 (0..30), both advance on step.
- Output bit `outn` by AUDCn, evaluated on step using post-advance LFSR values:
  - 0, 11: out = 1.
  - 1: out = poly4[0].
  - 2: poly4 advances only when div31 wraps to 0; out = poly4[0].
  - 3: poly4 advances only when poly5[0]=1; out = poly4[0].
  - 4, 5: out toggles.
  - 6, 10: out = 1 while div31 < 18, else 0.
  - 7, 9: out = poly5[0].
  - 8: out = poly9[0].
  - 12, 13: out toggles when div3 wraps to 0.
  - 14: out toggles when div31 wraps to 0.
  - 15: out toggles when div3 wraps to 0 and poly5[0]=1.
- Amplitude: ampn = outn ? AUDVn : 0. AudioOut <= amp0 + amp1 on every Clk, with a 5-bit result and no overflow (maximum 30).

## Timing
- Reset: all registers, dividers and aux counters are 0; LFSRs are all-ones; outn = 0; AudioOut = 0. Reset applied mid-operation returns the block to this state immediately.
- A register write at edge k is visible from edge k onward. If WrEn and AudTick are active in the same cycle, the tick uses the pre-write values.
- Latency:
  - Channel step at edge k → AudioOut updated at edge k+1.
  - AUDV write at edge k → AudioOut at edge k+1.
- AUDF lowered below the current count: the counter keeps incrementing, wraps 31→0, then compares against the new value. No early step is issued.
- AUDC change mid-stream: LFSR, divider and aux state are retained; the new mode applies from the next step.
- WrAddr 6–7: no state change.

## Structure
- Package `tia_audio_pkg` holds:
  - register address constants,
  - AUDC mode encodings,
  - LFSR seeds and feedback tap indices,
  - the div31 duty threshold (18).
- Sub-module `tia_audio_channel` contains the divider, LFSRs, aux counters and mode logic, and outputs amp[3:0]. It is instantiated twice. The top level contains the register file and the mixer register.

## Test plan
- **Reset and constant mode:** reset, then write AUDC0=0, AUDV0=15, AUDC1=0, AUDV1=15, then one AudTick → AudioOut = 30 one Clk after the step. Assert Reset → AudioOut = 0 immediately.
- **Square wave and divider:** AUDC0=4, AUDF0=0, AUDV0=15, channel 1 silent → AudioOut alternates 15, 0, 15, … on every tick. With AUDF0=3, the period is 8 ticks (4 high, 4 low).
- **poly4 sequence:** AUDC0=1, AUDF0=0, AUDV0=8 → first steps give 8, 8, 8, 0; the full pattern repeats with period 15 steps.
- **Duty cycle:** AUDC0=6, AUDF0=0, AUDV0=1 → 18 ticks at 1, then 13 ticks at 0, repeating.
- **Write/tick collision:** write AUDV0 in the same cycle as AudTick → the step uses the old AUDV0; the new value appears at AudioOut one Clk later. Lowering AUDF0 from 20 to 2 at count 10 → next step after 21+3 more ticks.
- **Randomized reference check:** random AUDC/AUDF/AUDV values and random tick spacing, compared against a behavioural reference model over 10k ticks → AudioOut matches cycle-exactly.

Source files
------------

// File: rtl/tia_audio_pkg.sv
// Shared constants for the TIA audio block:
// register map, AUDC modes, LFSR seeds/taps.
package tia_audio_pkg;

  localparam logic [2:0] ADDR_AUDC0 = 3'd0;
  localparam logic [2:0] ADDR_AUDC1 = 3'd1;
  localparam logic [2:0] ADDR_AUDF0 = 3'd2;
  localparam logic [2:0] ADDR_AUDF1 = 3'd3;
  localparam logic [2:0] ADDR_AUDV0 = 3'd4;
  localparam logic [2:0] ADDR_AUDV1 = 3'd5;

  typedef enum logic [3:0] {
    MODE_SET     = 4'd0,
    MODE_POLY4   = 4'd1,
    MODE_D31_P4  = 4'd2,
    MODE_P5_P4   = 4'd3,
    MODE_SQ_A    = 4'd4,
    MODE_SQ_B    = 4'd5,
    MODE_DUTY_A  = 4'd6,
    MODE_POLY5_A = 4'd7,
    MODE_POLY9   = 4'd8,
    MODE_POLY5_B = 4'd9,
    MODE_DUTY_B  = 4'd10,
    MODE_SET_B   = 4'd11,
    MODE_DIV6_A  = 4'd12,
    MODE_DIV6_B  = 4'd13,
    MODE_DIV93   = 4'd14,
    MODE_P5DIV6  = 4'd15
  } audc_e;

  localparam logic [3:0] P4_SEED = 4'hF;
  localparam logic [4:0] P5_SEED = 5'h1F;
  localparam logic [8:0] P9_SEED = 9'h1FF;

  // Feedback is p[0] ^ p[TAP]
  localparam int P4_TAP = 1;
  localparam int P5_TAP = 2;
  localparam int P9_TAP = 4;

  localparam logic [4:0] DUTY_TH = 5'd18;

endpackage

// File: rtl/tia_audio_channel.sv
// One TIA audio channel: divider, LFSRs,
// aux counters and AUDC mode output.
module tia_audio_channel
  import tia_audio_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick_i,
  input  logic [3:0] audc_i,
  input  logic [4:0] audf_i,
  input  logic [3:0] audv_i,
  output logic [3:0] amp_o
);

  logic [4:0] div_q, div_d;
  logic [1:0] d3_q, d3_d, d3_n;
  logic [4:0] d31_q, d31_d, d31_n;
  logic [3:0] p4_q, p4_d, p4_n;
  logic [4:0] p5_q, p5_d, p5_n;
  logic [8:0] p9_q, p9_d, p9_n;
  logic       out_q, out_d;
  logic       step;
  logic       p4_adv;
  audc_e      mode;

  assign mode  = audc_e'(audc_i);
  assign step  = tick_i && (div_q == audf_i);
  assign d3_n  = (d3_q == 2'd2) ? 2'd0 : d3_q + 2'd1;
  assign d31_n = (d31_q == 5'd30) ? 5'd0
                                  : d31_q + 5'd1;
  assign p4_n  = {p4_q[0] ^ p4_q[P4_TAP], p4_q[3:1]};
  assign p5_n  = {p5_q[0] ^ p5_q[P5_TAP], p5_q[4:1]};
  assign p9_n  = {p9_q[0] ^ p9_q[P9_TAP], p9_q[8:1]};

  always_comb begin
    p4_adv = 1'b1;
    case (mode)
      MODE_D31_P4: p4_adv = (d31_n == 5'd0);
      MODE_P5_P4:  p4_adv = p5_n[0];
      default:     p4_adv = 1'b1;
    endcase
  end

  always_comb begin
    div_d = div_q;
    d3_d  = d3_q;
    d31_d = d31_q;
    p4_d  = p4_q;
    p5_d  = p5_q;
    p9_d  = p9_q;
    out_d = out_q;
    if (tick_i)
      div_d = step ? 5'd0 : div_q + 5'd1;
    if (step) begin
      d3_d  = d3_n;
      d31_d = d31_n;
      p5_d  = p5_n;
      p9_d  = p9_n;
      if (p4_adv)
        p4_d = p4_n;
      case (mode)
        MODE_SET, MODE_SET_B:
          out_d = 1'b1;
        MODE_POLY4, MODE_D31_P4, MODE_P5_P4:
          out_d = p4_d[0];
        MODE_SQ_A, MODE_SQ_B:
          out_d = ~out_q;
        MODE_DUTY_A, MODE_DUTY_B:
          out_d = (d31_n < DUTY_TH);
        MODE_POLY5_A, MODE_POLY5_B:
          out_d = p5_n[0];
        MODE_POLY9:
          out_d = p9_n[0];
        MODE_DIV6_A, MODE_DIV6_B:
          out_d = out_q ^ (d3_n == 2'd0);
        MODE_DIV93:
          out_d = out_q ^ (d31_n == 5'd0);
        MODE_P5DIV6:
          out_d = out_q ^ ((d3_n == 2'd0) && p5_n[0]);
        default:
          out_d = out_q;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q <= '0;
      d3_q  <= '0;
      d31_q <= '0;
      p4_q  <= P4_SEED;
      p5_q  <= P5_SEED;
      p9_q  <= P9_SEED;
      out_q <= 1'b0;
    end else begin
      div_q <= div_d;
      d3_q  <= d3_d;
      d31_q <= d31_d;
      p4_q  <= p4_d;
      p5_q  <= p5_d;
      p9_q  <= p9_d;
      out_q <= out_d;
    end
  end

  assign amp_o = out_q ? audv_i : 4'd0;

endmodule

// File: rtl/tia_audio.sv
// Two-channel TIA audio: register file,
// two channel generators and the mixer.
module tia_audio
  import tia_audio_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       AudTick,
  input  logic       WrEn,
  input  logic [2:0] WrAddr,
  input  logic [4:0] WrData,
  output logic [4:0] AudioOut
);

  logic [3:0] audc0_q, audc0_d, audc1_q, audc1_d;
  logic [4:0] audf0_q, audf0_d, audf1_q, audf1_d;
  logic [3:0] audv0_q, audv0_d, audv1_q, audv1_d;
  logic [3:0] amp0, amp1;
  logic [4:0] mix_q, mix_d;

  always_comb begin
    audc0_d = audc0_q;
    audc1_d = audc1_q;
    audf0_d = audf0_q;
    audf1_d = audf1_q;
    audv0_d = audv0_q;
    audv1_d = audv1_q;
    if (WrEn) begin
      case (WrAddr)
        ADDR_AUDC0: audc0_d = WrData[3:0];
        ADDR_AUDC1: audc1_d = WrData[3:0];
        ADDR_AUDF0: audf0_d = WrData;
        ADDR_AUDF1: audf1_d = WrData;
        ADDR_AUDV0: audv0_d = WrData[3:0];
        ADDR_AUDV1: audv1_d = WrData[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      audc0_q <= '0;
      audc1_q <= '0;
      audf0_q <= '0;
      audf1_q <= '0;
      audv0_q <= '0;
      audv1_q <= '0;
    end else begin
      audc0_q <= audc0_d;
      audc1_q <= audc1_d;
      audf0_q <= audf0_d;
      audf1_q <= audf1_d;
      audv0_q <= audv0_d;
      audv1_q <= audv1_d;
    end
  end

  // Channels see the pre-write registers on a
  // write/tick collision.
  tia_audio_channel u_ch0 (
    .Clk    (Clk),
    .Reset  (Reset),
    .tick_i (AudTick),
    .audc_i (audc0_q),
    .audf_i (audf0_q),
    .audv_i (audv0_q),
    .amp_o  (amp0)
  );

  tia_audio_channel u_ch1 (
    .Clk    (Clk),
    .Reset  (Reset),
    .tick_i (AudTick),
    .audc_i (audc1_q),
    .audf_i (audf1_q),
    .audv_i (audv1_q),
    .amp_o  (amp1)
  );

  assign mix_d = {1'b0, amp0} + {1'b0, amp1};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) mix_q <= '0;
    else       mix_q <= mix_d;
  end

  assign AudioOut = mix_q;

endmodule

// File: tb/tb_tia_audio.sv
// Self-checking bench for tia_audio: vector table,
// directed corner cases and a scoreboarded reference model.
module tb_tia_audio;

  logic       Clk;
  logic       Reset;
  logic       AudTick;
  logic       WrEn;
  logic [2:0] WrAddr;
  logic [4:0] WrData;
  logic [4:0] AudioOut;

  tia_audio dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .AudTick  (AudTick),
    .WrEn     (WrEn),
    .WrAddr   (WrAddr),
    .WrData   (WrData),
    .AudioOut (AudioOut)
  );

  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail   = 0;
  int last_out;
  int sbq[$];

  logic [3:0] m_audc[2];
  logic [4:0] m_audf[2];
  logic [3:0] m_audv[2];
  logic [4:0] m_div[2];
  int         m_d3[2];
  int         m_d31[2];
  logic [3:0] m_p4[2];
  logic [4:0] m_p5[2];
  logic [8:0] m_p9[2];
  logic       m_out[2];

  typedef struct {
    logic       rst;
    logic       tk;
    logic       we;
    logic [2:0] a;
    logic [4:0] d;
    int         exp;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input int got, input int exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_audc[c] = '0; m_audf[c] = '0; m_audv[c] = '0;
      m_div[c] = '0; m_d3[c] = 0; m_d31[c] = 0;
      m_p4[c] = 4'hF; m_p5[c] = 5'h1F; m_p9[c] = 9'h1FF;
      m_out[c] = 1'b0;
    end
  endtask

  task automatic m_tick(input int c);
    logic [3:0] p4;
    logic [4:0] p5;
    logic [8:0] p9;
    logic adv, o;
    int mode;
    if (m_div[c] != m_audf[c]) begin
      m_div[c] = m_div[c] + 5'd1;
      return;
    end
    m_div[c] = '0;
    mode = int'(m_audc[c]);
    m_d3[c] = (m_d3[c] + 1) % 3;
    m_d31[c] = (m_d31[c] + 1) % 31;
    p5 = m_p5[c];
    m_p5[c] = {p5[0] ^ p5[2], p5[4:1]};
    p9 = m_p9[c];
    m_p9[c] = {p9[0] ^ p9[4], p9[8:1]};
    p5 = m_p5[c];
    p9 = m_p9[c];
    adv = 1'b1;
    if (mode == 2) adv = (m_d31[c] == 0);
    if (mode == 3) adv = p5[0];
    p4 = m_p4[c];
    if (adv) m_p4[c] = {p4[0] ^ p4[1], p4[3:1]};
    p4 = m_p4[c];
    o = m_out[c];
    case (mode)
      0, 11:    o = 1'b1;
      1, 2, 3:  o = p4[0];
      4, 5:     o = ~o;
      6, 10:    o = (m_d31[c] < 18);
      7, 9:     o = p5[0];
      8:        o = p9[0];
      12, 13:   if (m_d3[c] == 0) o = ~o;
      14:       if (m_d31[c] == 0) o = ~o;
      default:  if (m_d3[c] == 0 && p5[0]) o = ~o;
    endcase
    m_out[c] = o;
  endtask

  task automatic model_edge();
    int e;
    e = (m_out[0] ? int'(m_audv[0]) : 0) + (m_out[1] ? int'(m_audv[1]) : 0);
    sbq.push_back(e);
    if (AudTick) begin
      m_tick(0);
      m_tick(1);
    end
    if (WrEn) begin
      case (WrAddr)
        3'd0: m_audc[0] = WrData[3:0];
        3'd1: m_audc[1] = WrData[3:0];
        3'd2: m_audf[0] = WrData;
        3'd3: m_audf[1] = WrData;
        3'd4: m_audv[0] = WrData[3:0];
        3'd5: m_audv[1] = WrData[3:0];
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic t, input logic we,
                     input logic [2:0] a, input logic [4:0] d);
    int e;
    AudTick = t; WrEn = we; WrAddr = a; WrData = d;
    model_edge();
    @(posedge Clk);
    #1;
    last_out = int'(AudioOut);
    if (sbq.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      check("sb", last_out, e);
    end
    AudTick = 1'b0; WrEn = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [4:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic tk();
    cyc(1'b1, 1'b0, 3'd0, 5'd0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 5'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("reset_async", int'(AudioOut), 0);
    sbq.delete();
    model_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[15] = '{1,1,1,0,0,0,1,0,0,1,1,0,1,0,1};
    Clk = 1'b0; Reset = 1'b1; AudTick = 1'b0;
    WrEn = 1'b0; WrAddr = '0; WrData = '0;
    model_reset();
    #12;
    check("reset_out", int'(AudioOut), 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // rst, tick, we, addr, data, AudioOut after edge
    vq.push_back('{1'b0, 1'b0, 1'b1, 3'd0, 5'd0,  0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 3'd4, 5'd15, 0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 3'd1, 5'd0,  0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 3'd5, 5'd15, 0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 5'd0,  0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 5'd0,  30});
    vq.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 5'd0,  30});
    vq.push_back('{1'b1, 1'b0, 1'b1, 3'd0, 5'd4,  0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 3'd4, 5'd15, 0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 5'd0,  0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 5'd0,  15});
    vq.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 5'd0,  0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 5'd0,  15});
    vq.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 5'd0,  0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 3'd6, 5'd31, 0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 3'd7, 5'd31, 0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 5'd0,  0});

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) do_reset();
      cyc(vq[i].tk, vq[i].we, vq[i].a, vq[i].d);
      check($sformatf("vec%0d", i), last_out, vq[i].exp);
    end

    // Square wave with AUDF0=3: 4 ticks high, 4 low
    do_reset();
    wr(3'd0, 5'd4); wr(3'd4, 5'd15); wr(3'd2, 5'd3);
    for (int i = 1; i <= 16; i++) begin
      tk(); idle();
      check($sformatf("sq_f3_t%0d", i), last_out, ((i / 4) % 2) * 15);
    end

    // Duty cycle mode
    do_reset();
    wr(3'd0, 5'd6); wr(3'd4, 5'd1);
    for (int s = 1; s <= 62; s++) begin
      tk(); idle();
      check($sformatf("duty_s%0d", s), last_out, ((s % 31) < 18) ? 1 : 0);
    end

    // poly4 sequence, period 15
    do_reset();
    wr(3'd0, 5'd1); wr(3'd4, 5'd8);
    for (int s = 1; s <= 30; s++) begin
      tk(); idle();
      check($sformatf("poly4_s%0d", s), last_out, pat[(s - 1) % 15] * 8);
    end

    // AUDV write colliding with a tick
    do_reset();
    wr(3'd0, 5'd0); wr(3'd4, 5'd5);
    tk(); idle();
    check("coll_pre", last_out, 5);
    cyc(1'b1, 1'b1, 3'd4, 5'd9);
    check("coll_edge", last_out, 5);
    idle();
    check("coll_post", last_out, 9);

    // AUDF lowered 20->2 at count 10, with a tick
    do_reset();
    wr(3'd0, 5'd4); wr(3'd4, 5'd15); wr(3'd2, 5'd20);
    for (int i = 0; i < 10; i++) tk();
    cyc(1'b1, 1'b1, 3'd2, 5'd2);
    for (int i = 1; i <= 24; i++) begin
      tk(); idle();
      check($sformatf("audf_low_t%0d", i), last_out, (i == 24) ? 15 : 0);
    end

    // Randomized run against the reference model
    do_reset();
    for (int t = 0; t < 10000; t++) begin
      int gap;
      if (t == 5000) do_reset();
      gap = $urandom_range(0, 2);
      for (int g = 0; g <= gap; g++) begin
        cyc((g == gap) ? 1'b1 : 1'b0,
            ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
